// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: 8-bit UART receiver, tick-gated FSM with a 3-sample majority vote per bit.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx_oversampler #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       break_det,
   output logic       busy
);
   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] SAMPLE_A = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] SAMPLE_B = CNT_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] SAMPLE_C = CNT_W'(OVERSAMPLE / 2 + 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} stateT;
   localparam stateT AFTER_DATA = PARITY;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} stateT;
   localparam stateT AFTER_DATA = STOP;
`endif

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   stateT            state;
   logic             rxMeta;
   logic             rxS;
   logic             armed;
   logic [CNT_W-1:0] sampleCnt;
   logic [CNT_W-1:0] cntNext;
   logic             cntWrap;
   logic [2:0]       bitCnt;
   logic             sampleA;
   logic             sampleB;
   logic             bitVote;
   logic [7:0]       shiftReg;
   logic             parityBad;

`ifdef UART_RX_PARITY_EN
   logic parityBit;
   logic parityErrReg;
   assign parityBad  = ^{shiftReg, parityBit};
   assign parity_err = parityErrReg;
`else
   assign parityBad  = 1'b0;
   assign parity_err = 1'b0;
`endif

   // sampleCnt holds the position of the previous tick; cntNext is the position of this tick
   always_comb begin
      cntWrap = (sampleCnt == CNT_LAST);
      cntNext = cntWrap ? '0 : sampleCnt + CNT_W'(1);
      bitVote = majority3(sampleA, sampleB, rxS);
   end

   // Bit datapath: vote samples and the LSB-first shift register
   always_ff @(posedge clk) begin
      if (tick && state != IDLE) begin
         if (cntNext == SAMPLE_A) sampleA <= rxS;
         if (cntNext == SAMPLE_B) sampleB <= rxS;
         if (state == DATA && cntNext == SAMPLE_C) shiftReg <= {bitVote, shiftReg[7:1]};
`ifdef UART_RX_PARITY_EN
         if (state == PARITY && cntNext == SAMPLE_C) parityBit <= bitVote;
`endif
      end
   end

   // Control: synchronizer, FSM, counters and registered status pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         rxMeta    <= 1'b1;
         rxS       <= 1'b1;
         state     <= IDLE;
         sampleCnt <= '0;
         bitCnt    <= '0;
         armed     <= 1'b0;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         break_det <= 1'b0;
         busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parityErrReg <= 1'b0;
`endif
      end else begin
         rxMeta    <= rx;
         rxS       <= rxMeta;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         break_det <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parityErrReg <= 1'b0;
`endif
         if (tick) begin
            case (state)
               IDLE: begin
                  sampleCnt <= '0;
                  // a break leaves the line low; only a high tick re-enables start detection
                  if (rxS) begin
                     armed <= 1'b1;
                  end else if (armed) begin
                     state <= START;
                     busy  <= 1'b1;
                  end
               end
               START: begin
                  sampleCnt <= cntNext;
                  if (cntNext == SAMPLE_C && bitVote) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     sampleCnt <= '0;
                  end else if (cntWrap) begin
                     state  <= DATA;
                     bitCnt <= '0;
                  end
               end
               DATA: begin
                  sampleCnt <= cntNext;
                  if (cntWrap) begin
                     bitCnt <= bitCnt + 3'd1;
                     if (bitCnt == 3'd7) state <= AFTER_DATA;
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  sampleCnt <= cntNext;
                  if (cntWrap) state <= STOP;
               end
`endif
               STOP: begin
                  sampleCnt <= cntNext;
                  // leave at mid-stop so a following start edge is caught with a 1-bit stop
                  if (cntNext == SAMPLE_C) begin
                     state     <= IDLE;
                     busy      <= 1'b0;
                     sampleCnt <= '0;
                     if (!bitVote) begin
                        frame_err <= 1'b1;
                        data      <= shiftReg;
                        if (shiftReg == 8'h00) begin
                           break_det <= 1'b1;
                           armed     <= 1'b0;
                        end
                     end else if (!parityBad) begin
                        valid <= 1'b1;
                        data  <= shiftReg;
                     end
`ifdef UART_RX_PARITY_EN
                     else parityErrReg <= 1'b1;
`endif
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Bench for uart_rx_oversampler: directed frames against a frame-level expectation queue.
`timescale 1ns/1ps
module tb_uart_rx_oversampler;
   localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
   localparam int STOP_IDX = 10;
   localparam int LAT_LITERAL = 172;
`else
   localparam int STOP_IDX = 9;
   localparam int LAT_LITERAL = 156;
`endif
   // line fall -> 2 sync flops -> detection tick is count 0 -> stop bit mid-sample + 1 registered clk
   localparam int PULSE_LAT = 3 + STOP_IDX * OS + OS / 2 + 1;

   logic       clk;
   logic       reset;
   logic       tick;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       parity_err;
   logic       break_det;
   logic       busy;

   uart_rx_oversampler #(.OVERSAMPLE(OS)) dut (
      .clk(clk), .reset(reset), .tick(tick), .rx(rx), .data(data), .valid(valid),
      .frame_err(frame_err), .parity_err(parity_err), .break_det(break_det), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic       v;
      logic       fe;
      logic       pe;
      logic       bd;
      logic [7:0] d;
      int         at;
   } expT;

   expT        expQ[$];
   expT        e;
   int         nCompared = 0;
   int         nFailed = 0;
   logic [7:0] dataExp = 8'h00;
   logic       checking = 1'b0;
   logic       prevBusy = 1'b0;
   logic       busyAtPulse = 1'b0;
   logic       busyBeforePulse = 1'b0;
   logic [3:0] lastKind = 4'b0000;
   int         lastPulseCyc = 0;
   int         lastFallCyc = 0;

   task automatic check(input string name, input int act, input int exp);
      nCompared++;
      if (act != exp) begin
         nFailed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Frame-level model: every status pulse must match the next queued frame outcome
   always @(negedge clk) begin
      if (checking) begin
         if (reset) begin
            dataExp = 8'h00;
         end else begin
            if (valid | frame_err | parity_err | break_det) begin
               lastPulseCyc    = cyc;
               busyAtPulse     = busy;
               busyBeforePulse = prevBusy;
               lastKind        = {valid, frame_err, parity_err, break_det};
               if (expQ.size() == 0) begin
                  check("unexpected pulse", int'(lastKind), 0);
               end else begin
                  e = expQ.pop_front();
                  check("pulse kind v/fe/pe/bd", int'(lastKind), int'({e.v, e.fe, e.pe, e.bd}));
                  if (e.at >= 0) check("pulse cycle", cyc, e.at);
                  if (e.v | e.fe) dataExp = e.d;
               end
            end
            check("data hold", int'(data), int'(dataExp));
         end
         prevBusy = busy;
      end
   end

   task automatic pushExp(input logic v, input logic fe, input logic pe, input logic bd,
                          input logic [7:0] d, input int at);
      expT x;
      x.v = v; x.fe = fe; x.pe = pe; x.bd = bd; x.d = d; x.at = at;
      expQ.push_back(x);
   endtask

   // One tick slot; with gap 0 tick stays high so ticks arrive every clk
   task automatic slot(input logic bitVal, input int gap);
      rx   = bitVal;
      tick = 1'b1;
      @(posedge clk); #1;
      if (gap > 0) begin
         tick = 1'b0;
         repeat (gap) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) slot(1'b1, 0);
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopBit, input logic parFlip,
                            input int gap, input int resetSlot);
      logic lineBits[0:10];
      lineBits[0] = 1'b0;
      for (int i = 0; i < 8; i++) lineBits[i + 1] = b[i];
`ifdef UART_RX_PARITY_EN
      lineBits[9] = (^b) ^ parFlip;
`endif
      lineBits[STOP_IDX] = stopBit;
      lastFallCyc = cyc;
      if (resetSlot < 0) begin
         if (!stopBit)     pushExp(1'b0, 1'b1, 1'b0, (b == 8'h00), b, gap == 0 ? cyc + PULSE_LAT : -1);
         else if (parFlip) pushExp(1'b0, 1'b0, 1'b1, 1'b0, b, gap == 0 ? cyc + PULSE_LAT : -1);
         else              pushExp(1'b1, 1'b0, 1'b0, 1'b0, b, gap == 0 ? cyc + PULSE_LAT : -1);
      end
      for (int s = 0; s <= STOP_IDX; s++) begin
         for (int k = 0; k < OS; k++) begin
            if (s * OS + k == resetSlot) reset = 1'b1;
            slot(lineBits[s], gap);
            reset = 1'b0;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      tick  = 1'b0;
      rx    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset data", int'(data), 8'h00);
      check("reset valid", int'(valid), 0);
      check("reset frame_err", int'(frame_err), 0);
      check("reset parity_err", int'(parity_err), 0);
      check("reset break_det", int'(break_det), 0);
      check("reset busy", int'(busy), 0);
      @(posedge clk); #1;
      checking = 1'b1;
      idle(20);

      // 0xA5 8N1: exact latency, busy falls with the valid pulse
      sendFrame(8'hA5, 1'b1, 1'b0, 0, -1);
      idle(4);
      check("A5 latency", lastPulseCyc - lastFallCyc, LAT_LITERAL);
      check("A5 busy at valid", int'(busyAtPulse), 0);
      check("A5 busy before valid", int'(busyBeforePulse), 1);
      check("A5 data", int'(data), 8'hA5);

      // false start: 4 low ticks then high
      lastFallCyc = cyc;
      repeat (4) slot(1'b0, 0);
      repeat (7) slot(1'b1, 0);
      @(negedge clk);
      check("false start busy at tick 8", int'(busy), 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("false start busy at tick 9", int'(busy), 0);
      @(posedge clk); #1;
      idle(8);

      // stop bit low on 0x3C
      sendFrame(8'h3C, 1'b0, 1'b0, 0, -1);
      idle(32);
      check("3C kind", int'(lastKind), 4'b0100);
      check("3C data", int'(data), 8'h3C);

      // 0x00 with good stop is a normal byte, not a break
      sendFrame(8'h00, 1'b1, 1'b0, 0, -1);
      idle(2);
      check("00 kind", int'(lastKind), 4'b1000);

      // back-to-back frames with a single stop bit
      sendFrame(8'h81, 1'b1, 1'b0, 0, -1);
      sendFrame(8'h7E, 1'b1, 1'b0, 0, -1);
      idle(4);
      check("back-to-back data", int'(data), 8'h7E);

      // sparse ticks: one tick every third clk
      sendFrame(8'h5A, 1'b1, 1'b0, 2, -1);
      idle(8);
      check("sparse tick data", int'(data), 8'h5A);

      // line held low for 20 bit periods
      pushExp(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, cyc + PULSE_LAT);
      repeat (20 * OS) slot(1'b0, 0);
      check("busy during break", int'(busy), 0);
      idle(OS);
      sendFrame(8'h55, 1'b1, 1'b0, 0, -1);
      idle(4);
      check("after break data", int'(data), 8'h55);

      // reset in the middle of data bit 4 of 0xFF, then 0x12
      sendFrame(8'hFF, 1'b1, 1'b0, 0, 5 * OS + 8);
      idle(4);
      check("after mid-frame reset data", int'(data), 8'h00);
      check("after mid-frame reset busy", int'(busy), 0);
      sendFrame(8'h12, 1'b1, 1'b0, 0, -1);
      idle(4);
      check("post-reset frame data", int'(data), 8'h12);

`ifdef UART_RX_PARITY_EN
      sendFrame(8'h07, 1'b1, 1'b0, 0, -1);
      idle(4);
      check("07 good parity kind", int'(lastKind), 4'b1000);
      sendFrame(8'h07, 1'b1, 1'b1, 0, -1);
      idle(4);
      check("07 bad parity kind", int'(lastKind), 4'b0010);
      check("07 bad parity data kept", int'(data), 8'h07);
`endif

      idle(4);
      check("outstanding expectations", expQ.size(), 0);
      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end
endmodule
